// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: synchronises and edge-detects interrupt lines, latches them
// as pending, and runs a raise/ack/done handshake with the core for the lowest-index enabled source.
module ext_irq_ctrl #(
    parameter int              NSRC     = 4,
    parameter int              ID_W     = 2,
    parameter logic [NSRC-1:0] MASK_RST = {NSRC{1'b1}}
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_src,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    input  logic            irq_ack,
    input  logic            irq_done,
    output logic            ExtIRQ,
    output logic [ID_W-1:0] irq_id,
    output logic [NSRC-1:0] pending,
    output logic            irq_lost
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ASSERT     = 2'd1,
        IN_SERVICE = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [NSRC-1:0] sync1_r;
    logic [NSRC-1:0] sync2_r;
    logic [NSRC-1:0] sync3_r;
    logic [NSRC-1:0] pending_r;
    logic [NSRC-1:0] mask_r;
    logic            irq_lost_r;
    logic            ext_irq_r;
    logic [ID_W-1:0] irq_id_r;
    logic            ext_irq_s;
    logic [ID_W-1:0] irq_id_s;
    logic [NSRC-1:0] clr_s;
    logic [NSRC-1:0] rise_s;
    logic [NSRC-1:0] req_s;

    // Fixed priority: the lowest set index wins.
    function automatic logic [ID_W-1:0] lowest_idx(input logic [NSRC-1:0] vec);
        lowest_idx = {ID_W{1'b0}};
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                lowest_idx = i[ID_W-1:0];
            end
        end
    endfunction

    assign rise_s   = sync2_r & ~sync3_r;
    assign req_s    = pending_r & mask_r;
    assign ExtIRQ   = ext_irq_r;
    assign irq_id   = irq_id_r;
    assign pending  = pending_r;
    assign irq_lost = irq_lost_r;

    // Handshake next-state, request/id outputs and the pending clear strobe.
    always_comb begin
        state_s   = state_r;
        ext_irq_s = ext_irq_r;
        irq_id_s  = irq_id_r;
        clr_s     = {NSRC{1'b0}};
        case (state_r)
            IDLE: begin
                if (req_s != {NSRC{1'b0}}) begin
                    state_s   = ASSERT;
                    ext_irq_s = 1'b1;
                    irq_id_s  = lowest_idx(req_s);
                end else begin
                    state_s   = IDLE;
                    ext_irq_s = 1'b0;
                end
            end
            ASSERT: begin
                // A simultaneous irq_done is deliberately ignored here.
                if (irq_ack) begin
                    state_s          = IN_SERVICE;
                    ext_irq_s        = 1'b0;
                    clr_s[irq_id_r]  = 1'b1;
                end else begin
                    state_s   = ASSERT;
                    ext_irq_s = 1'b1;
                end
            end
            IN_SERVICE: begin
                ext_irq_s = 1'b0;
                if (irq_done) begin
                    state_s = IDLE;
                end else begin
                    state_s = IN_SERVICE;
                end
            end
            default: begin
                state_s   = IDLE;
                ext_irq_s = 1'b0;
                irq_id_s  = {ID_W{1'b0}};
            end
        endcase
    end

    // All state: synchroniser, pending/lost/mask and the handshake registers.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            sync1_r    <= {NSRC{1'b0}};
            sync2_r    <= {NSRC{1'b0}};
            sync3_r    <= {NSRC{1'b0}};
            pending_r  <= {NSRC{1'b0}};
            mask_r     <= MASK_RST;
            irq_lost_r <= 1'b0;
            ext_irq_r  <= 1'b0;
            irq_id_r   <= {ID_W{1'b0}};
            state_r    <= IDLE;
        end else begin
            sync1_r    <= irq_src;
            sync2_r    <= sync1_r;
            sync3_r    <= sync2_r;
            // A new edge wins over the acknowledge clear of the same source.
            pending_r  <= rise_s | (pending_r & ~clr_s);
            irq_lost_r <= irq_lost_r | (|(rise_s & pending_r & ~clr_s));
            if (mask_we) begin
                mask_r <= mask_wdata;
            end else begin
                mask_r <= mask_r;
            end
            ext_irq_r  <= ext_irq_s;
            irq_id_r   <= irq_id_s;
            state_r    <= state_s;
        end
    end

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Self-checking bench for ext_irq_ctrl: directed scenarios with literal expectations plus a
// cycle-level behavioural model compared against the outputs on every falling clock edge.
module tb_ext_irq_ctrl;

    localparam int NSRC = 4;
    localparam int ID_W = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [NSRC-1:0] irq_src;
    logic            mask_we;
    logic [NSRC-1:0] mask_wdata;
    logic            irq_ack;
    logic            irq_done;
    logic            ExtIRQ;
    logic [ID_W-1:0] irq_id;
    logic [NSRC-1:0] pending;
    logic            irq_lost;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    ext_irq_ctrl #(.NSRC(NSRC), .ID_W(ID_W), .MASK_RST(4'b1111)) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .irq_src   (irq_src),
        .mask_we   (mask_we),
        .mask_wdata(mask_wdata),
        .irq_ack   (irq_ack),
        .irq_done  (irq_done),
        .ExtIRQ    (ExtIRQ),
        .irq_id    (irq_id),
        .pending   (pending),
        .irq_lost  (irq_lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: line samples since reset, pending set, handshake phase.
    logic [NSRC-1:0] seen [3];
    logic [NSRC-1:0] m_pend, m_mask, m_clr, m_new;
    logic            m_lost, m_irq;
    logic [ID_W-1:0] m_id;
    int              m_phase;   // 0 waiting, 1 raised, 2 in service

    always @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 3; k++) seen[k] = '0;
            m_pend = '0; m_mask = 4'b1111; m_lost = 1'b0;
            m_irq = 1'b0; m_id = '0; m_phase = 0;
        end else begin
            // A line counts as newly risen once it was sampled high after having been sampled low.
            m_new = seen[1] & ~seen[2];
            m_clr = '0;
            if (m_phase == 0) begin
                for (int i = NSRC - 1; i >= 0; i--)
                    if (m_pend[i] && m_mask[i]) m_id = ID_W'(i);
                if ((m_pend & m_mask) != 0) begin m_irq = 1'b1; m_phase = 1; end
            end else if (m_phase == 1) begin
                if (irq_ack) begin m_clr[m_id] = 1'b1; m_irq = 1'b0; m_phase = 2; end
            end else if (irq_done) begin
                m_phase = 0;
            end
            if ((m_new & m_pend & ~m_clr) != 0) m_lost = 1'b1;
            m_pend = m_new | (m_pend & ~m_clr);
            if (mask_we) m_mask = mask_wdata;
            seen[2] = seen[1];
            seen[1] = seen[0];
            seen[0] = irq_src;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_ExtIRQ", 32'(ExtIRQ), 32'(m_irq));
            chk("model_irq_id", 32'(irq_id), 32'(m_id));
            chk("model_pending", 32'(pending), 32'(m_pend));
            chk("model_irq_lost", 32'(irq_lost), 32'(m_lost));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    endtask

    task automatic pulse_done();
        irq_done = 1'b1; tick(1); irq_done = 1'b0;
    endtask

    initial begin
        reset = 1'b0; irq_src = '0; mask_we = 1'b0; mask_wdata = '0;
        irq_ack = 1'b0; irq_done = 1'b0;
        tick(2);
        cmp_en = 1'b1;
        chk("reset_ExtIRQ", 32'(ExtIRQ), 32'd0);
        chk("reset_pending", 32'(pending), 32'd0);
        reset = 1'b1;
        tick(1);

        // 1: single request latency and handshake
        irq_src = 4'b0100;
        tick(3);
        chk("t1_pending_E2", 32'(pending), 32'h4);
        chk("t1_ExtIRQ_E2", 32'(ExtIRQ), 32'd0);
        tick(1);
        chk("t1_ExtIRQ_E3", 32'(ExtIRQ), 32'd1);
        chk("t1_irq_id", 32'(irq_id), 32'd2);
        pulse_ack();
        chk("t1_ExtIRQ_ack", 32'(ExtIRQ), 32'd0);
        chk("t1_pending_ack", 32'(pending), 32'd0);
        pulse_done();
        tick(3);
        chk("t1_ExtIRQ_idle", 32'(ExtIRQ), 32'd0);

        // 2: priority and queuing
        irq_src = 4'b1010;
        tick(4);
        chk("t2_first_irq", 32'(ExtIRQ), 32'd1);
        chk("t2_first_id", 32'(irq_id), 32'd1);
        pulse_ack();
        chk("t2_pending_after_ack", 32'(pending), 32'h8);
        pulse_done();
        chk("t2_gap_cycle", 32'(ExtIRQ), 32'd0);
        tick(1);
        chk("t2_second_irq", 32'(ExtIRQ), 32'd1);
        chk("t2_second_id", 32'(irq_id), 32'd3);
        pulse_ack();
        pulse_done();
        irq_src = 4'b0000;
        tick(3);

        // 3: masking
        mask_we = 1'b1; mask_wdata = 4'b1110; tick(1); mask_we = 1'b0;
        irq_src = 4'b0001;
        tick(3);
        chk("t3_pending_masked", 32'(pending), 32'h1);
        for (int c = 0; c < 10; c++) begin
            tick(1);
            chk("t3_masked_quiet", 32'(ExtIRQ), 32'd0);
        end
        mask_we = 1'b1; mask_wdata = 4'b1111; tick(1); mask_we = 1'b0;
        chk("t3_unmask_edge1", 32'(ExtIRQ), 32'd0);
        tick(1);
        chk("t3_unmask_edge2", 32'(ExtIRQ), 32'd1);
        chk("t3_unmask_id", 32'(irq_id), 32'd0);
        pulse_ack();
        pulse_done();
        irq_src = 4'b0000;
        tick(1);

        // 4: collision on the ack edge, then a lost edge
        irq_src = 4'b0100;
        tick(4);
        chk("t4_raise_id", 32'(irq_id), 32'd2);
        irq_src = 4'b0000; tick(2);
        irq_src = 4'b0100; tick(2);
        pulse_ack();
        chk("t4_collision_pending", 32'(pending), 32'h4);
        chk("t4_collision_lost", 32'(irq_lost), 32'd0);
        pulse_done();
        tick(1);
        chk("t4_rearm_irq", 32'(ExtIRQ), 32'd1);
        irq_src = 4'b0000; tick(2);
        irq_src = 4'b0100; tick(3);
        chk("t4_lost_set", 32'(irq_lost), 32'd1);
        pulse_ack();
        pulse_done();
        tick(3);
        chk("t4_lost_sticky", 32'(irq_lost), 32'd1);
        irq_src = 4'b0000;
        tick(2);

        // 5: stray handshake pulses and a held level
        pulse_ack();
        chk("t5_stray_ack", 32'(ExtIRQ), 32'd0);
        pulse_done();
        chk("t5_stray_done_idle", 32'(pending), 32'd0);
        irq_src = 4'b0001;
        tick(4);
        chk("t5_raise", 32'(ExtIRQ), 32'd1);
        pulse_done();
        chk("t5_done_in_assert", 32'(ExtIRQ), 32'd1);
        tick(14);
        chk("t5_held_irq", 32'(ExtIRQ), 32'd1);
        chk("t5_held_pending", 32'(pending), 32'h1);
        pulse_ack();
        pulse_done();
        tick(4);
        chk("t5_single_event_irq", 32'(ExtIRQ), 32'd0);
        chk("t5_single_event_pend", 32'(pending), 32'd0);
        irq_src = 4'b0000;
        tick(2);

        // 6: reset in the middle of service
        irq_src = 4'b1010;
        tick(4);
        pulse_ack();
        irq_src = 4'b1000; tick(2);
        irq_src = 4'b1010; tick(3);
        mask_we = 1'b1; mask_wdata = 4'b0100; tick(1); mask_we = 1'b0;
        chk("t6_pre_reset_pend", 32'(pending), 32'hA);
        chk("t6_pre_reset_irq", 32'(ExtIRQ), 32'd0);
        reset = 1'b0; tick(1); reset = 1'b1;
        chk("t6_rst_ExtIRQ", 32'(ExtIRQ), 32'd0);
        chk("t6_rst_irq_id", 32'(irq_id), 32'd0);
        chk("t6_rst_pending", 32'(pending), 32'd0);
        chk("t6_rst_lost", 32'(irq_lost), 32'd0);
        tick(3);
        chk("t6_new_edge_pend", 32'(pending), 32'hA);
        chk("t6_new_edge_quiet", 32'(ExtIRQ), 32'd0);
        tick(1);
        chk("t6_new_request", 32'(ExtIRQ), 32'd1);
        chk("t6_new_request_id", 32'(irq_id), 32'd1);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
